// File: rtl/debounce_event_array.sv
// Per-channel push-button conditioner: synchroniser, tick-paced debouncer,
// and a hold FSM producing press / release / long-press / auto-repeat pulses.
// All channels share one sample-tick prescaler; everything else is per channel.
module debounce_event_array #(
  parameter int BITS         = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int TICK_DIV     = 1000,
  parameter int WAIT_COUNT   = 3,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic            CLOCK,
  input  logic            CPU_RESETN,
  input  logic [BITS-1:0] BTN_IN,
  output logic [BITS-1:0] BTN_OUT,
  output logic [BITS-1:0] BTN_PRESS,
  output logic [BITS-1:0] BTN_RELEASE,
  output logic [BITS-1:0] BTN_LONG,
  output logic [BITS-1:0] BTN_REPEAT
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_LONG
  } hold_state_e;

  // Counter widths; a zero limit still gets a 1-bit counter that never moves.
  localparam int DB_W   = $clog2(WAIT_COUNT + 1);
  localparam int HOLD_W = (LONG_TICKS   > 0) ? $clog2(LONG_TICKS + 1)   : 1;
  localparam int REP_W  = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;

  // Terminal counts: a counter equal to its LAST value means "this tick completes it".
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(WAIT_COUNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((LONG_TICKS   > 0) ? LONG_TICKS   - 1 : 0);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

  logic tick;

  // ---------------------------------------------------------------------
  // Shared sample-tick prescaler
  // ---------------------------------------------------------------------
  if (TICK_DIV > 1) begin : g_div
    localparam int DIV_W = $clog2(TICK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign tick = (div_cnt == DIV_LAST);

    // Free-running 0..TICK_DIV-1 counter; explicit wrap keeps it in range.
    always_ff @(posedge CLOCK or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
        div_cnt <= '0;
      end else if (tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end else begin : g_nodiv
    assign tick = 1'b1;
  end

  // ---------------------------------------------------------------------
  // Per-channel pipeline
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < BITS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    logic [DB_W-1:0]        db_cnt_q;
    logic [DB_W-1:0]        db_cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   rise;
    logic                   fall;

    hold_state_e            state_q;
    hold_state_e            state_d;
    logic [HOLD_W-1:0]      hold_q;
    logic [HOLD_W-1:0]      hold_d;
    logic [REP_W-1:0]       rep_q;
    logic [REP_W-1:0]       rep_d;
    logic                   long_d;
    logic                   repeat_d;

    logic                   press_q;
    logic                   release_q;
    logic                   long_q;
    logic                   repeat_q;

    // Metastability synchroniser; the debouncer only ever sees its last stage.
    always_ff @(posedge CLOCK or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], BTN_IN[i]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce: count consecutive disagreeing ticks, any agreeing tick restarts.
    always_comb begin
      db_cnt_d = db_cnt_q;
      level_d  = level_q;
      if (tick) begin
        if (s != level_q) begin
          if (db_cnt_q == DB_LAST) begin
            level_d  = s;
            db_cnt_d = '0;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end else begin
          db_cnt_d = '0;
        end
      end
    end

    // The level flips on this edge; event registers load in the same edge so
    // each pulse coincides with the first cycle of the new level.
    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // Debounced level and its counter.
    always_ff @(posedge CLOCK or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
        db_cnt_q <= '0;
        level_q  <= 1'b0;
      end else begin
        db_cnt_q <= db_cnt_d;
        level_q  <= level_d;
      end
    end

    // Hold FSM next-state and pulse decode; a falling level overrides all.
    always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      rep_d    = rep_q;
      long_d   = 1'b0;
      repeat_d = 1'b0;
      if (fall) begin
        state_d = ST_IDLE;
        hold_d  = '0;
        rep_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rise) begin
              state_d = ST_HELD;
              hold_d  = '0;
            end
          end
          ST_HELD: begin
            if ((LONG_TICKS > 0) && tick) begin
              if (hold_q == HOLD_LAST) begin
                state_d = ST_LONG;
                long_d  = 1'b1;
                hold_d  = '0;
                rep_d   = '0;
              end else begin
                hold_d = hold_q + 1'b1;
              end
            end
          end
          ST_LONG: begin
            if ((REPEAT_TICKS > 0) && tick) begin
              if (rep_q == REP_LAST) begin
                repeat_d = 1'b1;
                rep_d    = '0;
              end else begin
                rep_d = rep_q + 1'b1;
              end
            end
          end
          default: begin
            state_d = ST_IDLE;
            hold_d  = '0;
            rep_d   = '0;
          end
        endcase
      end
    end

    // Hold FSM state and counters.
    always_ff @(posedge CLOCK or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
        state_q <= ST_IDLE;
        hold_q  <= '0;
        rep_q   <= '0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        rep_q   <= rep_d;
      end
    end

    // Registered single-cycle event pulses.
    always_ff @(posedge CLOCK or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        press_q   <= rise;
        release_q <= fall;
        long_q    <= long_d;
        repeat_q  <= repeat_d;
      end
    end

    assign BTN_OUT[i]     = level_q;
    assign BTN_PRESS[i]   = press_q;
    assign BTN_RELEASE[i] = release_q;
    assign BTN_LONG[i]    = long_q;
    assign BTN_REPEAT[i]  = repeat_q;
  end

endmodule

// File: tb/tb_debounce_event_array.sv
// Self-checking bench for debounce_event_array (TICK_DIV=1, WAIT=3, LONG=8, REPEAT=4).
// Expected pulses are queued with their absolute cycle when stimulus is driven and
// compared every cycle at the falling clock edge; absent entries mean all pulses 0.
module tb_debounce_event_array;

  localparam int BITS = 4;

  logic            CLOCK      = 1'b0;
  logic            CPU_RESETN = 1'b1;
  logic [BITS-1:0] BTN_IN     = '0;
  logic [BITS-1:0] BTN_OUT;
  logic [BITS-1:0] BTN_PRESS;
  logic [BITS-1:0] BTN_RELEASE;
  logic [BITS-1:0] BTN_LONG;
  logic [BITS-1:0] BTN_REPEAT;

  debounce_event_array #(
    .BITS        (BITS),
    .SYNC_STAGES (2),
    .TICK_DIV    (1),
    .WAIT_COUNT  (3),
    .LONG_TICKS  (8),
    .REPEAT_TICKS(4)
  ) dut (
    .CLOCK      (CLOCK),
    .CPU_RESETN (CPU_RESETN),
    .BTN_IN     (BTN_IN),
    .BTN_OUT    (BTN_OUT),
    .BTN_PRESS  (BTN_PRESS),
    .BTN_RELEASE(BTN_RELEASE),
    .BTN_LONG   (BTN_LONG),
    .BTN_REPEAT (BTN_REPEAT)
  );

  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  // Event word layout: {repeat, long, release, press}
  localparam logic [15:0] P1 = 16'h0002;
  localparam logic [15:0] L1 = 16'h0200;
  localparam logic [15:0] R1 = 16'h2000;
  localparam logic [15:0] X1 = 16'h0020;

  typedef struct {
    int          at;
    logic [15:0] ev;
  } exp_t;

  exp_t        sb[$];
  logic [3:0]  exp_level = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  // Sorted insert; events due in the same cycle are merged.
  task automatic push_ev(input int at, input logic [15:0] ev);
    int   pos;
    exp_t e;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].at == at) begin
        sb[i].ev = sb[i].ev | ev;
        return;
      end
    end
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].at > at) begin
        pos = i;
        break;
      end
    end
    e.at = at;
    e.ev = ev;
    sb.insert(pos, e);
  endtask

  task automatic test_reset();
    int          c0;
    logic [15:0] got;
    logic [15:0] exp_ev;
    BTN_IN = 4'hF;
    #2 CPU_RESETN = 1'b0;
    exp_level = '0;
    repeat (4) begin
      @(negedge CLOCK);
      got = {BTN_REPEAT, BTN_LONG, BTN_RELEASE, BTN_PRESS};
      n_cmp++;
      if (got !== 16'h0 || BTN_OUT !== 4'h0) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d events=%h level=%h required 0", cyc, got, BTN_OUT);
      end
    end
    c0 = cyc;
    CPU_RESETN = 1'b1;
    push_ev(c0 + 5, 16'h000F);
    while (cyc < c0 + 16) begin
      @(negedge CLOCK);
      exp_ev = '0;
      if (sb.size() > 0 && sb[0].at == cyc) begin
        exp_ev = sb[0].ev;
        void'(sb.pop_front());
      end
      exp_level = (exp_level | exp_ev[3:0]) & ~exp_ev[7:4];
      got = {BTN_REPEAT, BTN_LONG, BTN_RELEASE, BTN_PRESS};
      n_cmp++;
      if (got !== exp_ev) begin
        n_err++;
        $display("FAIL reset_events t=%0d got=%h required=%h", cyc - c0, got, exp_ev);
      end
      n_cmp++;
      if (BTN_OUT !== exp_level) begin
        n_err++;
        $display("FAIL reset_level t=%0d got=%h required=%h", cyc - c0, BTN_OUT, exp_level);
      end
      if (cyc == c0 + 6) begin
        BTN_IN = 4'h0;
        push_ev(cyc + 5, 16'h00F0);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL reset_missing pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_glitch();
    int          c0;
    logic [15:0] got;
    logic [15:0] exp_ev;
    @(negedge CLOCK);
    c0 = cyc;
    BTN_IN[0] = 1'b1;
    while (cyc < c0 + 14) begin
      @(negedge CLOCK);
      exp_ev = '0;
      if (sb.size() > 0 && sb[0].at == cyc) begin
        exp_ev = sb[0].ev;
        void'(sb.pop_front());
      end
      exp_level = (exp_level | exp_ev[3:0]) & ~exp_ev[7:4];
      got = {BTN_REPEAT, BTN_LONG, BTN_RELEASE, BTN_PRESS};
      n_cmp++;
      if (got !== exp_ev) begin
        n_err++;
        $display("FAIL glitch_events t=%0d got=%h required=%h", cyc - c0, got, exp_ev);
      end
      n_cmp++;
      if (BTN_OUT !== exp_level) begin
        n_err++;
        $display("FAIL glitch_level t=%0d got=%h required=%h", cyc - c0, BTN_OUT, exp_level);
      end
      if (cyc == c0 + 2) BTN_IN[0] = 1'b0;
      if (cyc == c0 + 3) BTN_IN[0] = 1'b1;
      if (cyc == c0 + 5) BTN_IN[0] = 1'b0;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL glitch_missing pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_long_repeat();
    int          c0;
    logic [15:0] got;
    logic [15:0] exp_ev;
    @(negedge CLOCK);
    c0 = cyc;
    BTN_IN[1] = 1'b1;
    push_ev(c0 + 5, P1);
    push_ev(c0 + 13, L1);
    for (int k = 17; k <= 33; k += 4) push_ev(c0 + k, R1);
    while (cyc < c0 + 45) begin
      @(negedge CLOCK);
      exp_ev = '0;
      if (sb.size() > 0 && sb[0].at == cyc) begin
        exp_ev = sb[0].ev;
        void'(sb.pop_front());
      end
      exp_level = (exp_level | exp_ev[3:0]) & ~exp_ev[7:4];
      got = {BTN_REPEAT, BTN_LONG, BTN_RELEASE, BTN_PRESS};
      n_cmp++;
      if (got !== exp_ev) begin
        n_err++;
        $display("FAIL long_events t=%0d got=%h required=%h", cyc - c0, got, exp_ev);
      end
      n_cmp++;
      if (BTN_OUT !== exp_level) begin
        n_err++;
        $display("FAIL long_level t=%0d got=%h required=%h", cyc - c0, BTN_OUT, exp_level);
      end
      if (cyc == c0 + 30) begin
        BTN_IN[1] = 1'b0;
        push_ev(cyc + 5, X1);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL long_missing pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_release_race();
    int          c0;
    logic [15:0] got;
    logic [15:0] exp_ev;
    @(negedge CLOCK);
    c0 = cyc;
    BTN_IN[1] = 1'b1;
    push_ev(c0 + 5, P1);
    while (cyc < c0 + 24) begin
      @(negedge CLOCK);
      exp_ev = '0;
      if (sb.size() > 0 && sb[0].at == cyc) begin
        exp_ev = sb[0].ev;
        void'(sb.pop_front());
      end
      exp_level = (exp_level | exp_ev[3:0]) & ~exp_ev[7:4];
      got = {BTN_REPEAT, BTN_LONG, BTN_RELEASE, BTN_PRESS};
      n_cmp++;
      if (got !== exp_ev) begin
        n_err++;
        $display("FAIL race_events t=%0d got=%h required=%h", cyc - c0, got, exp_ev);
      end
      n_cmp++;
      if (BTN_OUT !== exp_level) begin
        n_err++;
        $display("FAIL race_level t=%0d got=%h required=%h", cyc - c0, BTN_OUT, exp_level);
      end
      // Level falls at t=13, the very cycle the long press would complete.
      if (cyc == c0 + 8) begin
        BTN_IN[1] = 1'b0;
        push_ev(cyc + 5, X1);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL race_missing pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_independent();
    int          c0;
    logic [15:0] got;
    logic [15:0] exp_ev;
    @(negedge CLOCK);
    c0 = cyc;
    BTN_IN[3:2] = 2'b11;
    push_ev(c0 + 5, 16'h000C);
    while (cyc < c0 + 20) begin
      @(negedge CLOCK);
      exp_ev = '0;
      if (sb.size() > 0 && sb[0].at == cyc) begin
        exp_ev = sb[0].ev;
        void'(sb.pop_front());
      end
      exp_level = (exp_level | exp_ev[3:0]) & ~exp_ev[7:4];
      got = {BTN_REPEAT, BTN_LONG, BTN_RELEASE, BTN_PRESS};
      n_cmp++;
      if (got !== exp_ev) begin
        n_err++;
        $display("FAIL indep_events t=%0d got=%h required=%h", cyc - c0, got, exp_ev);
      end
      n_cmp++;
      if (BTN_OUT !== exp_level) begin
        n_err++;
        $display("FAIL indep_level t=%0d got=%h required=%h", cyc - c0, BTN_OUT, exp_level);
      end
      if (cyc == c0 + 7) begin
        BTN_IN[3:2] = 2'b00;
        push_ev(cyc + 5, 16'h00C0);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL indep_missing pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_mid_reset();
    int          c0;
    int          c1;
    logic [15:0] got;
    logic [15:0] exp_ev;
    logic [19:0] all_out;
    @(negedge CLOCK);
    c0 = cyc;
    BTN_IN[1] = 1'b1;
    push_ev(c0 + 5, P1);
    push_ev(c0 + 13, L1);
    while (cyc < c0 + 15) begin
      @(negedge CLOCK);
      exp_ev = '0;
      if (sb.size() > 0 && sb[0].at == cyc) begin
        exp_ev = sb[0].ev;
        void'(sb.pop_front());
      end
      exp_level = (exp_level | exp_ev[3:0]) & ~exp_ev[7:4];
      got = {BTN_REPEAT, BTN_LONG, BTN_RELEASE, BTN_PRESS};
      n_cmp++;
      if (got !== exp_ev) begin
        n_err++;
        $display("FAIL midrst_pre_events t=%0d got=%h required=%h", cyc - c0, got, exp_ev);
      end
      n_cmp++;
      if (BTN_OUT !== exp_level) begin
        n_err++;
        $display("FAIL midrst_pre_level t=%0d got=%h required=%h", cyc - c0, BTN_OUT, exp_level);
      end
    end
    // Channel 1 is in the long-hold state here with BTN_OUT high.
    CPU_RESETN = 1'b0;
    exp_level = '0;
    #1;
    all_out = {BTN_REPEAT, BTN_LONG, BTN_RELEASE, BTN_PRESS, BTN_OUT};
    n_cmp++;
    if (all_out !== 20'h0) begin
      n_err++;
      $display("FAIL midrst_async got=%h required=0", all_out);
    end
    repeat (3) begin
      @(negedge CLOCK);
      all_out = {BTN_REPEAT, BTN_LONG, BTN_RELEASE, BTN_PRESS, BTN_OUT};
      n_cmp++;
      if (all_out !== 20'h0) begin
        n_err++;
        $display("FAIL midrst_hold got=%h required=0", all_out);
      end
    end
    c1 = cyc;
    CPU_RESETN = 1'b1;
    push_ev(c1 + 5, P1);
    push_ev(c1 + 13, L1);
    push_ev(c1 + 17, R1);
    push_ev(c1 + 21, R1);
    while (cyc < c1 + 30) begin
      @(negedge CLOCK);
      exp_ev = '0;
      if (sb.size() > 0 && sb[0].at == cyc) begin
        exp_ev = sb[0].ev;
        void'(sb.pop_front());
      end
      exp_level = (exp_level | exp_ev[3:0]) & ~exp_ev[7:4];
      got = {BTN_REPEAT, BTN_LONG, BTN_RELEASE, BTN_PRESS};
      n_cmp++;
      if (got !== exp_ev) begin
        n_err++;
        $display("FAIL midrst_post_events t=%0d got=%h required=%h", cyc - c1, got, exp_ev);
      end
      n_cmp++;
      if (BTN_OUT !== exp_level) begin
        n_err++;
        $display("FAIL midrst_post_level t=%0d got=%h required=%h", cyc - c1, BTN_OUT, exp_level);
      end
      if (cyc == c1 + 18) begin
        BTN_IN[1] = 1'b0;
        push_ev(cyc + 5, X1);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL midrst_missing pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_long_repeat();
    test_release_race();
    test_independent();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d required completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
